// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_ctrl_pkg
// Brief    : Register map, status/pending bit positions and FSM states for
//            the AXI4-Lite UART control block.
// Revision : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

    localparam logic [2:0] c_reg_rxdata   = 3'd0;
    localparam logic [2:0] c_reg_txdata   = 3'd1;
    localparam logic [2:0] c_reg_div      = 3'd2;
    localparam logic [2:0] c_reg_cfg      = 3'd3;
    localparam logic [2:0] c_reg_status   = 3'd4;
    localparam logic [2:0] c_reg_irq_en   = 3'd5;
    localparam logic [2:0] c_reg_irq_pend = 3'd6;
    localparam logic [2:0] c_reg_hole     = 3'd7;

    localparam int c_pend_rx  = 0;
    localparam int c_pend_tx  = 1;
    localparam int c_pend_ovr = 2;

    localparam logic [31:0] c_cfg_rst     = 32'h8400_0000;
    localparam logic [1:0]  c_resp_okay   = 2'b00;
    localparam logic [1:0]  c_resp_slverr = 2'b10;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

    function automatic logic [31:0] f_apply_wstrb(input logic [31:0] old_v,
                                                  input logic [31:0] new_v,
                                                  input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Brief    : Single-clock FIFO with exact level count; push when full is
//            dropped unless a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [P_WIDTH-1:0]       i_data,
    input  logic                     i_pop,
    output logic [P_WIDTH-1:0]       o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(P_DEPTH):0] o_level
);
    localparam int                c_pw       = $clog2(P_DEPTH);
    localparam logic [c_pw-1:0]   c_ptr_one  = 1;
    localparam logic [c_pw:0]     c_lvl_one  = 1;
    localparam logic [c_pw:0]     c_lvl_full = (c_pw+1)'(P_DEPTH);

    logic [P_WIDTH-1:0] r_mem [P_DEPTH];
    logic [c_pw-1:0]    r_wr_ptr;
    logic [c_pw-1:0]    r_rd_ptr;
    logic [c_pw:0]      r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_level == c_lvl_full);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            if (w_do_push && !w_do_pop)
                r_level <= r_level + c_lvl_one;
            else if (w_do_pop && !w_do_push)
                r_level <= r_level - c_lvl_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axil_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axil_uart_ctrl
// Brief    : AXI4-Lite register slave for the UART: TX/RX FIFOs, baud/frame
//            configuration, level status, overrun flag and level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module axil_uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int          P_S_AXI_DATA_WIDTH = 32,
    parameter int          P_S_AXI_ADDR_WIDTH = 16,
    parameter int          P_FIFO_DEPTH       = 16,
    parameter logic [23:0] P_DIV_RST          = 24'd434
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    input  logic [P_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [P_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [P_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [P_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [P_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [7:0]                      o_tx_data,
    output logic                            o_tx_valid,
    input  logic                            i_tx_ready,
    input  logic [7:0]                      i_rx_data,
    input  logic                            i_rx_valid,
    output logic [23:0]                     o_div_num,
    output logic [3:0]                      o_data_bit,
    output logic [1:0]                      o_stop_bit,
    output logic [1:0]                      o_check_bit,
    output logic                            o_irq
);
    localparam int c_lw = $clog2(P_FIFO_DEPTH) + 1;

    wr_state_t   r_wr_state;
    rd_state_t   r_rd_state;
    logic        r_awready, r_arready, r_bvalid, r_rvalid, r_overrun;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata, r_cfg;
    logic [23:0] r_div;
    logic [2:0]  r_irq_en;

    logic            w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [c_lw-1:0] w_tx_level, w_rx_level;
    logic [7:0]      w_rx_dout;
    logic [2:0]      w_wr_idx, w_rd_idx, w_pending;
    logic            w_wr_map, w_rd_map, w_aw_hs, w_ar_hs;
    logic            w_tx_wr, w_tx_push, w_tx_pop, w_rx_pop, w_ovr_set, w_pend_clr;
    logic [1:0]      w_wr_resp, w_rd_resp;
    logic [31:0]     w_rd_data, w_status, w_div_new, w_cfg_new, w_irq_en_new;
    logic            w_unused;

    assign w_wr_idx = s_axi_awaddr[4:2];
    assign w_rd_idx = s_axi_araddr[4:2];
    assign w_wr_map = (s_axi_awaddr[P_S_AXI_ADDR_WIDTH-1:5] == '0) && (w_wr_idx != c_reg_hole);
    assign w_rd_map = (s_axi_araddr[P_S_AXI_ADDR_WIDTH-1:5] == '0) && (w_rd_idx != c_reg_hole);
    assign w_aw_hs  = r_awready && s_axi_awvalid && s_axi_wvalid;
    assign w_ar_hs  = r_arready && s_axi_arvalid;

    assign w_tx_pop   = !w_tx_empty && i_tx_ready;
    assign w_tx_wr    = w_aw_hs && w_wr_map && (w_wr_idx == c_reg_txdata) && s_axi_wstrb[0];
    assign w_tx_push  = w_tx_wr && (!w_tx_full || w_tx_pop);
    assign w_wr_resp  = (!w_wr_map || (w_tx_wr && !w_tx_push)) ? c_resp_slverr : c_resp_okay;
    assign w_rx_pop   = w_ar_hs && w_rd_map && (w_rd_idx == c_reg_rxdata) && !w_rx_empty;
    // A same-cycle pop frees a slot, so a strobe while full is then not an overrun.
    assign w_ovr_set  = i_rx_valid && w_rx_full && !w_rx_pop;
    assign w_pend_clr = w_aw_hs && w_wr_map && (w_wr_idx == c_reg_irq_pend)
                        && s_axi_wstrb[0] && s_axi_wdata[c_pend_ovr];

    assign w_div_new    = f_apply_wstrb({8'h00, r_div}, s_axi_wdata, s_axi_wstrb);
    assign w_cfg_new    = f_apply_wstrb(r_cfg, s_axi_wdata, s_axi_wstrb);
    assign w_irq_en_new = f_apply_wstrb({29'd0, r_irq_en}, s_axi_wdata, s_axi_wstrb);

    assign w_pending = {r_overrun, w_tx_empty, !w_rx_empty};
    assign w_status  = {8'h00, 8'(w_tx_level), 8'(w_rx_level), 3'b000,
                        r_overrun, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};

    assign o_tx_valid    = !w_tx_empty;
    assign o_irq         = |(r_irq_en & w_pending);
    assign o_div_num     = r_div;
    assign o_data_bit    = r_cfg[31:28];
    assign o_stop_bit    = r_cfg[27:26];
    assign o_check_bit   = r_cfg[25:24];
    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_awready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign w_unused      = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                             w_div_new[31:24], w_irq_en_new[31:3]};

    uart_sync_fifo #(.P_WIDTH(8), .P_DEPTH(P_FIFO_DEPTH)) u_tx_fifo (
        .clk(s_axi_aclk), .rst_n(s_axi_aresetn),
        .i_push(w_tx_push), .i_data(s_axi_wdata[7:0]), .i_pop(w_tx_pop),
        .o_data(o_tx_data), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_level(w_tx_level)
    );

    uart_sync_fifo #(.P_WIDTH(8), .P_DEPTH(P_FIFO_DEPTH)) u_rx_fifo (
        .clk(s_axi_aclk), .rst_n(s_axi_aresetn),
        .i_push(i_rx_valid), .i_data(i_rx_data), .i_pop(w_rx_pop),
        .o_data(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_level(w_rx_level)
    );

    always_comb begin
        w_rd_data = 32'd0;
        w_rd_resp = c_resp_okay;
        case (w_rd_idx)
            c_reg_rxdata: begin
                if (w_rx_empty) w_rd_resp = c_resp_slverr;
                else            w_rd_data = {24'd0, w_rx_dout};
            end
            c_reg_div:      w_rd_data = {8'h00, r_div};
            c_reg_cfg:      w_rd_data = r_cfg;
            c_reg_status:   w_rd_data = w_status;
            c_reg_irq_en:   w_rd_data = {29'd0, r_irq_en};
            c_reg_irq_pend: w_rd_data = {29'd0, w_pending};
            default:        w_rd_data = 32'd0;
        endcase
        if (!w_rd_map) begin
            w_rd_data = 32'd0;
            w_rd_resp = c_resp_slverr;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_resp_okay;
            r_div      <= P_DIV_RST;
            r_cfg      <= c_cfg_rst;
            r_irq_en   <= 3'd0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awready  <= 1'b0;
                        r_bvalid   <= 1'b1;
                        r_bresp    <= w_wr_resp;
                        r_wr_state <= W_RESP;
                        if (w_wr_map && w_wr_idx == c_reg_div)    r_div    <= w_div_new[23:0];
                        if (w_wr_map && w_wr_idx == c_reg_cfg)    r_cfg    <= w_cfg_new;
                        if (w_wr_map && w_wr_idx == c_reg_irq_en) r_irq_en <= w_irq_en_new[2:0];
                    end else begin
                        r_awready <= s_axi_awvalid && s_axi_wvalid;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid   <= 1'b0;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rresp    <= c_resp_okay;
            r_rdata    <= 32'd0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rdata    <= w_rd_data;
                        r_rresp    <= w_rd_resp;
                        r_rd_state <= R_DATA;
                    end else begin
                        r_arready <= s_axi_arvalid;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_rvalid   <= 1'b0;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    // A new overrun in the same cycle as its W1C clear keeps the flag set.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn)  r_overrun <= 1'b0;
        else if (w_ovr_set)  r_overrun <= 1'b1;
        else if (w_pend_clr) r_overrun <= 1'b0;
    end

endmodule
`default_nettype wire
